// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transaction arbiter: FSM encoding, SPI modes,
// data width and a small sizing helper.
package spi_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4,
    ST_GAP   = 3'd5
  } state_e;

  // {polarity, phase}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first set request at or above ptr,
// wrapping, wins. ptr is always below NUM_REQ, so wrap is a compare-and-subtract.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   owner,
  output logic               any
);

  always_comb begin
    int idx;
    idx   = 0;
    owner = '0;
    any   = 1'b0;
    // Walk from the farthest offset down so the nearest requester is written last.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx]) begin
        owner = IDX_W'(idx);
        any   = 1'b1;
      end
    end
    grant = any ? (NUM_REQ'(1) << owner) : '0;
  end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Shares one SPI byte engine among NUM_REQ requesters: round-robin grant,
// CS setup, start/done handshake with timeout, response pulse and CS gap.
module spi_txn_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int SETUP_CYC   = 2,
  parameter int GAP_CYC     = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [8*NUM_REQ-1:0]  req_data,
  input  logic [2*NUM_REQ-1:0]  req_mode,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [7:0]            rsp_data,
  output logic                  rsp_err,
  output logic                  m_start,
  output logic [7:0]            m_data_wr,
  output logic                  m_polarity,
  output logic                  m_phase,
  input  logic                  m_done,
  input  logic [7:0]            m_data_rd,
  output logic [NUM_REQ-1:0]    cs_n,
  output logic                  busy,
  output logic [2:0]            state
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int CNT_MAX = max3(SETUP_CYC, GAP_CYC, TIMEOUT_CYC);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
  logic [IDX_W-1:0]     owner_q, owner_d, rr_ptr_q, ptr_next, arb_owner;
  logic [NUM_REQ-1:0]   arb_grant, owner_oh_d;
  logic                 arb_any, cs_active_d;

  logic [NUM_REQ-1:0]   req_ready_q, rsp_valid_q, cs_n_q;
  logic [DATA_W-1:0]    rsp_data_q, m_data_wr_q;
  logic                 rsp_err_q, m_start_q, m_polarity_q, m_phase_q, busy_q;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (arb_grant),
    .owner (arb_owner),
    .any   (arb_any)
  );

  assign cnt_inc     = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
  assign owner_d     = (state_q == ST_IDLE) ? arb_owner : owner_q;
  assign ptr_next    = (arb_owner == IDX_W'(NUM_REQ - 1)) ? '0 : arb_owner + IDX_W'(1);
  assign owner_oh_d  = NUM_REQ'(1) << owner_d;
  assign cs_active_d = (state_d == ST_SETUP) || (state_d == ST_START) ||
                       (state_d == ST_WAIT)  || (state_d == ST_RESP);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE:  if (arb_any) begin state_d = ST_SETUP; cnt_d = '0; end
      ST_SETUP: if (cnt_q == CNT_W'(SETUP_CYC - 1)) state_d = ST_START; else cnt_d = cnt_inc;
      ST_START: begin state_d = ST_WAIT; cnt_d = '0; end
      ST_WAIT:  if (m_done || cnt_q == CNT_W'(TIMEOUT_CYC - 1)) state_d = ST_RESP;
                else cnt_d = cnt_inc;
      ST_RESP:  begin state_d = ST_GAP; cnt_d = '0; end
      ST_GAP:   if (cnt_q == CNT_W'(GAP_CYC - 1)) state_d = ST_IDLE; else cnt_d = cnt_inc;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      req_ready_q  <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      m_start_q    <= 1'b0;
      m_data_wr_q  <= '0;
      m_polarity_q <= 1'b0;
      m_phase_q    <= 1'b0;
      cs_n_q       <= '1;
      busy_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      req_ready_q <= '0;
      m_start_q   <= (state_d == ST_START);
      busy_q      <= (state_d != ST_IDLE);
      rsp_valid_q <= (state_d == ST_RESP) ? owner_oh_d : '0;
      cs_n_q      <= cs_active_d ? ~owner_oh_d : '1;
      if (state_q == ST_IDLE && arb_any) begin
        req_ready_q  <= arb_grant;
        rr_ptr_q     <= ptr_next;
        m_data_wr_q  <= req_data[DATA_W*int'(arb_owner) +: DATA_W];
        m_polarity_q <= req_mode[2*int'(arb_owner) + 1];
        m_phase_q    <= req_mode[2*int'(arb_owner)];
      end
      if (state_q == ST_WAIT && state_d == ST_RESP) begin
        rsp_data_q <= m_done ? m_data_rd : '0;
        rsp_err_q  <= ~m_done;
      end
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;
  assign m_start    = m_start_q;
  assign m_data_wr  = m_data_wr_q;
  assign m_polarity = m_polarity_q;
  assign m_phase    = m_phase_q;
  assign cs_n       = cs_n_q;
  assign busy       = busy_q;
  assign state      = state_q;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Randomized self-checking bench for spi_txn_arbiter with a behavioural
// spi_master model (done N cycles after start, echoing the inverted byte).
module tb_spi_txn_arbiter;
  localparam int NR = 2;
  localparam int S  = 2;
  localparam int G  = 4;
  localparam int T  = 1024;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [8*NR-1:0] req_data = '0;
  logic [2*NR-1:0] req_mode = '0;
  logic [NR-1:0]   req_ready, rsp_valid, cs_n;
  logic [7:0]      rsp_data, m_data_wr, m_data_rd;
  logic            rsp_err, m_start, m_polarity, m_phase, m_done, busy;
  logic [2:0]      state;

  logic       model_done = 1'b0, spur_done = 1'b0;
  logic [7:0] model_rd = '0;
  int         model_n = 3;
  bit         model_en = 1'b1;
  bit         hook_req1 = 1'b0, hook_spur = 1'b0;

  int n_checks = 0, n_pass = 0, cs_viol = 0, ref_ptr = 0;

  int          obs_gnt, obs_rsp, obs_start_off, obs_rsp_off, obs_idle_state;
  logic [NR-1:0] obs_gnt_vec;
  logic [7:0]  obs_wr, obs_rdata;
  logic        obs_pol, obs_pha, obs_err;
  bit          obs_stable, obs_cs_ok, obs_gap_ok;

  assign m_done    = model_done | spur_done;
  assign m_data_rd = model_rd;

  always #5 clk = ~clk;

  spi_txn_arbiter #(.NUM_REQ(NR), .SETUP_CYC(S), .GAP_CYC(G), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_mode(req_mode), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .m_start(m_start),
    .m_data_wr(m_data_wr), .m_polarity(m_polarity), .m_phase(m_phase),
    .m_done(m_done), .m_data_rd(m_data_rd), .cs_n(cs_n), .busy(busy), .state(state)
  );

  always @(negedge clk) if ($countones(~cs_n) > 1) cs_viol++;

  // spi_master model
  always begin
    @(posedge clk); #1;
    if (m_start === 1'b1 && model_en) begin
      logic [7:0] d;
      int n;
      d = ~m_data_wr;
      n = model_n;
      repeat (n) @(posedge clk);
      #2 model_done = 1'b1; model_rd = d;
      @(posedge clk); #2 model_done = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic int ref_owner(input logic [NR-1:0] v);
    int idx;
    for (int k = 0; k < NR; k++) begin
      idx = (ref_ptr + k) % NR;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic int vec_idx(input logic [NR-1:0] v);
    for (int k = 0; k < NR; k++) if (v[k]) return k;
    return -1;
  endfunction

  task automatic do_txn(input logic [NR-1:0] vld, input bit drop);
    req_valid = vld;
    obs_gnt_vec = '0;
    for (int c = 0; c < 64; c++) begin
      step();
      if (req_ready != '0) break;
    end
    obs_gnt_vec = req_ready;
    obs_gnt = vec_idx(req_ready);
    obs_wr = m_data_wr; obs_pol = m_polarity; obs_pha = m_phase;
    if (drop) req_valid = '0;
    obs_start_off = -1; obs_rsp_off = -1; obs_rsp = -1;
    obs_rdata = '0; obs_err = 1'b0;
    obs_stable = 1'b1; obs_gap_ok = 1'b1;
    obs_cs_ok = (cs_n === ~obs_gnt_vec);
    for (int c = 1; c < 3000; c++) begin
      step();
      if (m_data_wr !== obs_wr || m_polarity !== obs_pol || m_phase !== obs_pha) obs_stable = 1'b0;
      if (cs_n !== ~obs_gnt_vec) obs_cs_ok = 1'b0;
      if (m_start === 1'b1 && obs_start_off < 0) obs_start_off = c;
      if (rsp_valid != '0) begin
        obs_rsp_off = c; obs_rsp = vec_idx(rsp_valid);
        obs_rdata = rsp_data; obs_err = rsp_err;
        break;
      end
    end
    for (int g = 1; g <= G; g++) begin
      step();
      if (hook_req1 && g == 1) req_valid = 2'b10;
      if (hook_spur) spur_done = (g == 1);
      if (m_data_wr !== obs_wr || m_polarity !== obs_pol || m_phase !== obs_pha) obs_stable = 1'b0;
      if (cs_n !== '1 || busy !== 1'b1 || state !== 3'd5 || rsp_valid !== '0) obs_gap_ok = 1'b0;
    end
    spur_done = 1'b0;
    step();
    obs_idle_state = int'(state);
    $display("txn gnt=%0d wr=%h mode=%b%b start@%0d rsp=%0d@%0d data=%h err=%b",
             obs_gnt, obs_wr, obs_pol, obs_pha, obs_start_off, obs_rsp, obs_rsp_off, obs_rdata, obs_err);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    n_checks++; if (state !== 3'd0) $display("FAIL reset_state got=%0d exp=0", state); else n_pass++;
    n_checks++; if (cs_n !== 2'b11) $display("FAIL reset_cs_n got=%b exp=11", cs_n); else n_pass++;
    n_checks++; if ({busy, m_start, rsp_err, m_polarity, m_phase} !== 5'b0)
      $display("FAIL reset_flags got=%b exp=00000", {busy, m_start, rsp_err, m_polarity, m_phase}); else n_pass++;
    n_checks++; if ({req_ready, rsp_valid, rsp_data, m_data_wr} !== 20'h0)
      $display("FAIL reset_data got=%h exp=0", {req_ready, rsp_valid, rsp_data, m_data_wr}); else n_pass++;
    reset = 1'b0;
    ref_ptr = 0;
  endtask

  task automatic test_single();
    req_data = {8'h00, 8'hAB}; req_mode = 4'b0000; model_n = 3;
    do_txn(2'b01, 1'b1);
    ref_ptr = 1;
    n_checks++; if (obs_gnt_vec !== 2'b01) $display("FAIL single_ready got=%b exp=01", obs_gnt_vec); else n_pass++;
    n_checks++; if (obs_wr !== 8'hAB) $display("FAIL single_wr got=%h exp=ab", obs_wr); else n_pass++;
    n_checks++; if (!obs_cs_ok) $display("FAIL single_cs got=0 exp=1"); else n_pass++;
    n_checks++; if (obs_start_off != S) $display("FAIL single_start_off got=%0d exp=%0d", obs_start_off, S); else n_pass++;
    n_checks++; if (obs_rsp_off != S + 3 + 1) $display("FAIL single_rsp_off got=%0d exp=%0d", obs_rsp_off, S + 4); else n_pass++;
    n_checks++; if (obs_rsp != 0 || obs_rdata !== 8'h54 || obs_err !== 1'b0)
      $display("FAIL single_rsp got=%0d/%h/%b exp=0/54/0", obs_rsp, obs_rdata, obs_err); else n_pass++;
    n_checks++; if (!obs_gap_ok || obs_idle_state != 0)
      $display("FAIL single_gap got=%0d/%0d exp=1/0", obs_gap_ok, obs_idle_state); else n_pass++;
  endtask

  task automatic test_alternate();
    int exp;
    req_data = 16'($urandom); req_mode = 4'($urandom);
    for (int i = 0; i < 4; i++) begin
      model_n = $urandom_range(1, 5);
      exp = ref_owner(2'b11);
      do_txn(2'b11, 1'b0);
      n_checks++; if (obs_gnt != exp) $display("FAIL alt_grant%0d got=%0d exp=%0d", i, obs_gnt, exp); else n_pass++;
      n_checks++; if (obs_rdata !== ~req_data[8*exp +: 8])
        $display("FAIL alt_rsp%0d got=%h exp=%h", i, obs_rdata, ~req_data[8*exp +: 8]); else n_pass++;
      ref_ptr = (exp + 1) % NR;
    end
    req_valid = '0;
  endtask

  task automatic test_mode_change();
    req_data = {8'h3C, 8'h5A}; req_mode = {2'b01, 2'b00};
    hook_req1 = 1'b1;
    do_txn(2'b01, 1'b1);
    hook_req1 = 1'b0;
    n_checks++; if (obs_gnt != 0) $display("FAIL mode_first got=%0d exp=0", obs_gnt); else n_pass++;
    do_txn(2'b10, 1'b1);
    ref_ptr = 0;
    n_checks++; if (obs_gnt != 1 || obs_wr !== 8'h3C) $display("FAIL mode_grant got=%0d/%h exp=1/3c", obs_gnt, obs_wr); else n_pass++;
    n_checks++; if ({obs_pol, obs_pha} !== 2'b01) $display("FAIL mode_polpha got=%b%b exp=01", obs_pol, obs_pha); else n_pass++;
    n_checks++; if (!obs_stable) $display("FAIL mode_stable got=0 exp=1"); else n_pass++;
    n_checks++; if (obs_rdata !== 8'hC3) $display("FAIL mode_rsp got=%h exp=c3", obs_rdata); else n_pass++;
  endtask

  task automatic test_timeout();
    model_en = 1'b0;
    req_data = 16'($urandom);
    do_txn(2'b01, 1'b1);
    model_en = 1'b1;
    ref_ptr = 1;
    n_checks++; if (obs_rsp_off != S + T + 1) $display("FAIL timeout_off got=%0d exp=%0d", obs_rsp_off, S + T + 1); else n_pass++;
    n_checks++; if (obs_rsp != 0 || obs_err !== 1'b1 || obs_rdata !== 8'h00)
      $display("FAIL timeout_rsp got=%0d/%b/%h exp=0/1/00", obs_rsp, obs_err, obs_rdata); else n_pass++;
    n_checks++; if (!obs_gap_ok || obs_idle_state != 0)
      $display("FAIL timeout_recover got=%0d/%0d exp=1/0", obs_gap_ok, obs_idle_state); else n_pass++;
  endtask

  task automatic test_reset_wait();
    bit got, ok;
    model_n = 10;
    req_valid = 2'b01;
    got = 1'b0;
    for (int c = 0; c < 64 && !got; c++) begin step(); got = (req_ready != '0); end
    req_valid = '0;
    n_checks++; if (!got) $display("FAIL rstwait_grant got=0 exp=1"); else n_pass++;
    for (int c = 0; c < 64 && m_start !== 1'b1; c++) step();
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    ref_ptr = 0;
    n_checks++; if (state !== 3'd0 || cs_n !== 2'b11 || rsp_valid !== '0 || busy !== 1'b0)
      $display("FAIL rstwait_after got=%0d/%b/%b/%b exp=0/11/00/0", state, cs_n, rsp_valid, busy); else n_pass++;
    ok = 1'b1;
    repeat (20) begin step(); if (rsp_valid !== '0 || state !== 3'd0) ok = 1'b0; end
    n_checks++; if (!ok) $display("FAIL rstwait_late_done got=0 exp=1"); else n_pass++;
    model_n = 3;
  endtask

  task automatic test_spurious();
    bit ok;
    ok = 1'b1;
    spur_done = 1'b1; step(); spur_done = 1'b0;
    repeat (3) begin if (rsp_valid !== '0 || state !== 3'd0) ok = 1'b0; step(); end
    n_checks++; if (!ok) $display("FAIL spur_idle got=0 exp=1"); else n_pass++;
    hook_spur = 1'b1;
    do_txn(2'b01, 1'b1);
    hook_spur = 1'b0;
    ref_ptr = 1;
    n_checks++; if (!obs_gap_ok || obs_idle_state != 0)
      $display("FAIL spur_gap got=%0d/%0d exp=1/0", obs_gap_ok, obs_idle_state); else n_pass++;
  endtask

  task automatic test_random();
    int exp;
    logic [NR-1:0] v;
    for (int i = 0; i < 8; i++) begin
      v = NR'($urandom_range(1, 3));
      req_data = 16'($urandom); req_mode = 4'($urandom);
      model_n = $urandom_range(1, 6);
      exp = ref_owner(v);
      do_txn(v, 1'b1);
      n_checks++; if (obs_gnt != exp) $display("FAIL rnd%0d_grant got=%0d exp=%0d", i, obs_gnt, exp); else n_pass++;
      n_checks++; if (obs_wr !== req_data[8*exp +: 8] || {obs_pol, obs_pha} !== req_mode[2*exp +: 2])
        $display("FAIL rnd%0d_latch got=%h/%b%b exp=%h/%b", i, obs_wr, obs_pol, obs_pha,
                 req_data[8*exp +: 8], req_mode[2*exp +: 2]); else n_pass++;
      n_checks++; if (obs_start_off != S || obs_rsp_off != S + model_n + 1)
        $display("FAIL rnd%0d_timing got=%0d/%0d exp=%0d/%0d", i, obs_start_off, obs_rsp_off, S, S + model_n + 1); else n_pass++;
      n_checks++; if (obs_rsp != exp || obs_rdata !== ~req_data[8*exp +: 8] || obs_err !== 1'b0)
        $display("FAIL rnd%0d_rsp got=%0d/%h/%b exp=%0d/%h/0", i, obs_rsp, obs_rdata, obs_err, exp, ~req_data[8*exp +: 8]); else n_pass++;
      n_checks++; if (!obs_cs_ok || !obs_stable || !obs_gap_ok || obs_idle_state != 0)
        $display("FAIL rnd%0d_seq got=%0d%0d%0d/%0d exp=111/0", i, obs_cs_ok, obs_stable, obs_gap_ok, obs_idle_state); else n_pass++;
      ref_ptr = (exp + 1) % NR;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_mode_change();
    test_timeout();
    test_reset_wait();
    test_spurious();
    test_random();
    n_checks++; if (cs_viol != 0) $display("FAIL cs_onehot got=%0d exp=0", cs_viol); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
